// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game state store.
// Optional build macro: SNAKE_WRAP_EN (grid wraps at the borders, no walls).
package snake_pkg;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int CELL_SHIFT = 4;

  typedef enum logic [1:0] {
    CELL_NONE = 2'b00,
    CELL_HEAD = 2'b01,
    CELL_BODY = 2'b10,
    CELL_WALL = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic {
    ST_ALIVE = 1'b0,
    ST_DEAD  = 1'b1
  } state_t;

  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
  } coord_t;

  // Opposite directions differ only in bit 0 with this encoding.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head computation with reversal rejection.
// With SNAKE_WRAP_EN defined the head wraps around the grid and never hits a wall.
module snake_next_head
  import snake_pkg::*;
(
  input  coord_t     head,
  input  dir_t       cur_dir,
  input  logic [1:0] dir_in,
  output coord_t     next_head,
  output dir_t       next_dir,
  output logic       hit_wall
);

  // Resolve direction (reverse requests keep the current heading) and step one cell.
  always_comb begin
    next_dir  = (dir_t'(dir_in) == opposite(cur_dir)) ? cur_dir : dir_t'(dir_in);
    next_head = head;
    case (next_dir)
`ifdef SNAKE_WRAP_EN
      DIR_UP:    next_head.y = (head.y == 5'd0) ? 5'(GRID_H - 1) : head.y - 5'd1;
      DIR_DOWN:  next_head.y = (head.y == 5'(GRID_H - 1)) ? 5'd0 : head.y + 5'd1;
      DIR_LEFT:  next_head.x = (head.x == 6'd0) ? 6'(GRID_W - 1) : head.x - 6'd1;
      DIR_RIGHT: next_head.x = (head.x == 6'(GRID_W - 1)) ? 6'd0 : head.x + 6'd1;
`else
      DIR_UP:    next_head.y = head.y - 5'd1;
      DIR_DOWN:  next_head.y = head.y + 5'd1;
      DIR_LEFT:  next_head.x = head.x - 6'd1;
      DIR_RIGHT: next_head.x = head.x + 6'd1;
`endif
      default:   next_head = head;
    endcase
  end

  // A living head is never on the border, so landing on one means entering a wall.
`ifdef SNAKE_WRAP_EN
  assign hit_wall = 1'b0;
`else
  assign hit_wall = (next_head.x == 6'd0) || (next_head.x == 6'(GRID_W - 1)) ||
                    (next_head.y == 5'd0) || (next_head.y == 5'(GRID_H - 1));
`endif

endmodule

// File: rtl/snake_cell_map.sv
// Snake segment store, movement/collision FSM and per-pixel cell lookup.
// Optional build macro: SNAKE_WRAP_EN (wrap-around grid, no WALL cells).
module snake_cell_map
  import snake_pkg::*;
#(
  parameter int MAX_LEN   = 16,
  parameter int START_LEN = 3,
  parameter int START_X   = 10,
  parameter int START_Y   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       move_tick,
  input  logic [1:0] dir_in,
  input  logic       grow,
  input  logic       restart,
  output logic [1:0] snake,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [4:0] length,
  output logic       dead,
  output logic       hit_self
);

  coord_t seg [MAX_LEN];
  dir_t   cur_dir;
  state_t state;
  logic   grow_pend;

  coord_t nh;
  dir_t   next_dir;
  logic   hit_wall;
  logic   grow_eff;
  logic   self_hit;
  int     chk_len;

  function automatic coord_t init_seg(input int i);
    coord_t c;
    c.x = '0;
    c.y = '0;
    if (i < START_LEN) begin
      c.x = 6'(START_X - i);
      c.y = 5'(START_Y);
    end
    return c;
  endfunction

  snake_next_head u_next_head (
    .head      (seg[0]),
    .cur_dir   (cur_dir),
    .dir_in    (dir_in),
    .next_head (nh),
    .next_dir  (next_dir),
    .hit_wall  (hit_wall)
  );

  assign head_x   = seg[0].x;
  assign head_y   = seg[0].y;
  assign grow_eff = grow_pend | grow;

  // Self collision: the tail vacates its cell during the move unless the snake grows.
  always_comb begin
    chk_len  = int'(length) - (grow_eff ? 0 : 1);
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < chk_len && seg[i] == nh) self_hit = 1'b1;
    end
  end

  // Snake state machine: moves, growth, death and restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
      length    <= 5'(START_LEN);
      cur_dir   <= DIR_RIGHT;
      grow_pend <= 1'b0;
      state     <= ST_ALIVE;
      dead      <= 1'b0;
      hit_self  <= 1'b0;
    end else begin
      case (state)
        ST_ALIVE: begin
          if (move_tick) begin
            grow_pend <= 1'b0;
            if (hit_wall || self_hit) begin
              state    <= ST_DEAD;
              dead     <= 1'b1;
              hit_self <= self_hit & ~hit_wall;
            end else begin
              for (int i = 1; i < MAX_LEN; i++) seg[i] <= seg[i-1];
              seg[0]  <= nh;
              cur_dir <= next_dir;
              if (grow_eff && length < 5'(MAX_LEN)) length <= length + 5'd1;
            end
          end else if (grow) begin
            grow_pend <= 1'b1;
          end
        end
        ST_DEAD: begin
          if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
            length    <= 5'(START_LEN);
            cur_dir   <= DIR_RIGHT;
            grow_pend <= 1'b0;
            state     <= ST_ALIVE;
            dead      <= 1'b0;
            hit_self  <= 1'b0;
          end
        end
        default: state <= ST_DEAD;
      endcase
    end
  end

  // Pixel to cell lookup: low four pixel bits only select a position inside a cell.
  logic [5:0] cx, cy;
  logic       on_screen, on_border;
  logic       is_head, is_body;
  cell_t      cell_nxt;
  logic       unused_pix;

  assign cx         = x_pos[9:CELL_SHIFT];
  assign cy         = y_pos[9:CELL_SHIFT];
  assign unused_pix = ^{x_pos[CELL_SHIFT-1:0], y_pos[CELL_SHIFT-1:0]};
  assign on_screen  = (x_pos < 10'd640) && (y_pos < 10'd480);
  assign on_border  = (cx == 6'd0) || (cx == 6'(GRID_W - 1)) ||
                      (cy == 6'd0) || (cy == 6'(GRID_H - 1));

  // Classify the scanned cell by priority WALL > HEAD > BODY > NONE.
  always_comb begin
    is_head = (seg[0].x == cx) && ({1'b0, seg[0].y} == cy);
    is_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (i < int'(length) && seg[i].x == cx && {1'b0, seg[i].y} == cy) is_body = 1'b1;
    end
    cell_nxt = CELL_NONE;
    if (on_screen) begin
`ifndef SNAKE_WRAP_EN
      if (on_border)    cell_nxt = CELL_WALL;
      else
`endif
      if (is_head)      cell_nxt = CELL_HEAD;
      else if (is_body) cell_nxt = CELL_BODY;
    end
  end

`ifdef SNAKE_WRAP_EN
  logic unused_border;
  assign unused_border = on_border;
`endif

  // Registered cell code, one cycle behind the scan position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) snake <= CELL_NONE;
    else     snake <= cell_nxt;
  end

endmodule

// File: tb/tb_snake_cell_map.sv
// Directed self-checking bench for snake_cell_map.
module tb_snake_cell_map;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x_pos, y_pos;
  logic       move_tick, grow, restart;
  logic [1:0] dir_in;
  logic [1:0] snake;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [4:0] length;
  logic       dead, hit_self;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SNAKE_WRAP_EN
  localparam logic [1:0] EXP_WALL = 2'd0;
`else
  localparam logic [1:0] EXP_WALL = 2'd3;
`endif

  snake_cell_map dut (
    .clk       (clk),
    .rst       (rst),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .move_tick (move_tick),
    .dir_in    (dir_in),
    .grow      (grow),
    .restart   (restart),
    .snake     (snake),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .dead      (dead),
    .hit_self  (hit_self)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [9:0] x, input logic [9:0] y);
    x_pos = x;
    y_pos = y;
    tick();
  endtask

  task automatic move(input logic [1:0] d, input logic g);
    dir_in    = d;
    grow      = g;
    move_tick = 1'b1;
    tick();
    move_tick = 1'b0;
    grow      = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; x_pos = '0; y_pos = '0;
    move_tick = 1'b0; grow = 1'b0; restart = 1'b0; dir_in = 2'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_snake", snake, 0);
    chk("rst_hx", head_x, 10);
    chk("rst_hy", head_y, 15);
    chk("rst_len", length, 3);
    chk("rst_dead", dead, 0);
    chk("rst_hself", hit_self, 0);
    rst = 1'b0;

    // Lookup of the initial snake (10,15) (9,15) (8,15)
    look(160, 240); chk("lk_head", snake, 1);
    look(144, 240); chk("lk_body9", snake, 2);
    look(128, 240); chk("lk_body8", snake, 2);
    look(112, 240); chk("lk_none7", snake, 0);
    look(0, 240);   chk("lk_wallx0", snake, EXP_WALL);
    look(160, 464); chk("lk_wally29", snake, EXP_WALL);
    look(700, 240); chk("lk_offx", snake, 0);
    look(160, 480); chk("lk_offy", snake, 0);

    // Grow and move in the same cycle
    move(2'd3, 1'b1);
    chk("mg_hx", head_x, 11);
    chk("mg_hy", head_y, 15);
    chk("mg_len", length, 4);
    look(128, 240); chk("mg_body8", snake, 2);

    // Reverse request ignored
    move(2'd2, 1'b0);
    chk("rev_hx", head_x, 12);
    chk("rev_len", length, 4);

    // Pending grow, then up/left/down into own body
    grow = 1'b1; tick(); grow = 1'b0; tick();
    chk("pend_len", length, 4);
    move(2'd0, 1'b0);
    chk("up_hy", head_y, 14);
    chk("up_len", length, 5);
    move(2'd2, 1'b0);
    chk("left_hx", head_x, 11);
    move(2'd1, 1'b0);
    chk("self_dead", dead, 1);
    chk("self_hself", hit_self, 1);
    chk("self_hx", head_x, 11);
    chk("self_hy", head_y, 14);

    // Dead: moves and grows ignored, frozen snake still drawn
    move(2'd3, 1'b1);
    chk("dead_hx", head_x, 11);
    chk("dead_len", length, 5);
    look(176, 224); chk("dead_lk_head", snake, 1);

    restart = 1'b1; tick(); restart = 1'b0;
    chk("rs_hx", head_x, 10);
    chk("rs_hy", head_y, 15);
    chk("rs_len", length, 3);
    chk("rs_dead", dead, 0);
    chk("rs_hself", hit_self, 0);

    // No leftover growth from the dead period
    move(2'd3, 1'b0);
    chk("nogrow_len", length, 3);
    chk("nogrow_hx", head_x, 11);

    // Moving into the vacating tail cell is legal
    move(2'd0, 1'b1);
    chk("loop_len", length, 4);
    move(2'd2, 1'b0);
    move(2'd1, 1'b0);
    chk("tail_dead", dead, 0);
    chk("tail_hx", head_x, 10);
    chk("tail_hy", head_y, 15);

    // Grow to 7, then asynchronous reset mid-cycle
    move(2'd1, 1'b1);
    move(2'd1, 1'b1);
    move(2'd1, 1'b1);
    chk("g7_len", length, 7);
    chk("g7_hy", head_y, 18);
    look(160, 288); chk("g7_lk_head", snake, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_len", length, 3);
    chk("arst_snake", snake, 0);
    chk("arst_hx", head_x, 10);
    chk("arst_hy", head_y, 15);
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();

    // Run right into the border
    for (int k = 0; k < 28; k++) move(2'd3, 1'b0);
    chk("w38_hx", head_x, 38);
    chk("w38_dead", dead, 0);
    move(2'd3, 1'b0);
`ifdef SNAKE_WRAP_EN
    chk("w39_hx", head_x, 39);
    chk("w39_dead", dead, 0);
    move(2'd3, 1'b0);
    chk("wrap_hx", head_x, 0);
    chk("wrap_dead", dead, 0);
    look(0, 240); chk("wrap_lk_head", snake, 1);
`else
    chk("wall_dead", dead, 1);
    chk("wall_hself", hit_self, 0);
    chk("wall_hx", head_x, 38);
    look(608, 240); chk("wall_lk_head", snake, 1);
    look(624, 240); chk("wall_lk_wall", snake, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
